// File: rtl/pipe_hazard_ctrl.sv
// PipeHazardCtrl: hazard and stall controller for a five-stage pipeline.
// It covers load-use bubbles, multi-cycle divide stalls, memory wait stalls,
// and exception flushes.
// Optional build macro MEM_TIMEOUT_EN adds a memory-wait watchdog. The
// watchdog counts consecutive wait cycles and raises a one-cycle bus error.
// The bus error then flushes the pipeline like an exception.
// Pipeline register choice encoding: 00 flush, 01 load, 10 hold.
module pipe_hazard_ctrl #(
  parameter int DIV_CYCLES  = 8,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       ex_div_start,
  input  logic       mem_req,
  input  logic       mem_ready,
  input  logic       exc_req,
  output logic       pc_we,
  output logic [1:0] choice_ifid,
  output logic [1:0] choice_idex,
  output logic [1:0] choice_exmem,
  output logic [1:0] choice_memwb,
  output logic       div_busy,
  output logic       exc_ack,
  output logic       bus_err
);

  // Out-of-range parameters are rejected at elaboration time.
  if (DIV_CYCLES < 2 || DIV_CYCLES > 64) begin : gDivRange
    $error("DIV_CYCLES out of range 2..64");
  end
  if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 1023) begin : gMemRange
    $error("MEM_TIMEOUT out of range 1..1023");
  end

  localparam logic [1:0] FLUSH = 2'b00;
  localparam logic [1:0] LOAD  = 2'b01;
  localparam logic [1:0] HOLD  = 2'b10;

  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 2);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DIV_WAIT = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] divCnt_q, divCnt_d;
  // A memory wait that interrupts a divide must resume the divide afterwards.
  logic       divPend_q, divPend_d;

  logic memStall;
  logic timeout;
  logic inDiv;
  logic loadUse;

  assign memStall = mem_req & ~mem_ready;
  assign inDiv    = (state_q == DIV_WAIT) | ((state_q == MEM_WAIT) & divPend_q);
  assign loadUse  = ex_mem_read & (ex_rd != 5'd0) &
                    ((id_use_rs & (id_rs == ex_rd)) |
                     (id_use_rt & (id_rt == ex_rd)));

`ifdef MEM_TIMEOUT_EN
  localparam logic [9:0] TO_LAST = 10'(MEM_TIMEOUT - 1);

  logic [9:0] waitCnt_q, waitCnt_d;

  // The watchdog fires on the MEM_TIMEOUT-th consecutive wait cycle.
  assign timeout = memStall & (waitCnt_q == TO_LAST);

  // Consecutive memory-wait cycle counter, cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) waitCnt_q <= '0;
    else       waitCnt_q <= waitCnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  // State, divide counter and resume flag; reset aborts any stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      divCnt_q  <= '0;
      divPend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      divCnt_q  <= divCnt_d;
      divPend_q <= divPend_d;
    end
  end

  // Per-cycle decision in priority order: flush, memory wait, divide,
  // load-use, normal.
  always_comb begin
    state_d      = state_q;
    divCnt_d     = divCnt_q;
    divPend_d    = divPend_q;
`ifdef MEM_TIMEOUT_EN
    waitCnt_d    = waitCnt_q;
`endif
    pc_we        = 1'b1;
    choice_ifid  = LOAD;
    choice_idex  = LOAD;
    choice_exmem = LOAD;
    choice_memwb = LOAD;
    div_busy     = 1'b0;
    exc_ack      = 1'b0;
    bus_err      = 1'b0;

    if (exc_req | timeout) begin
      choice_ifid  = FLUSH;
      choice_idex  = FLUSH;
      choice_exmem = FLUSH;
      choice_memwb = FLUSH;
      exc_ack      = exc_req;
      bus_err      = timeout;
      state_d      = RUN;
      divCnt_d     = '0;
      divPend_d    = 1'b0;
`ifdef MEM_TIMEOUT_EN
      waitCnt_d    = '0;
`endif
    end else if (memStall) begin
      pc_we        = 1'b0;
      choice_ifid  = HOLD;
      choice_idex  = HOLD;
      choice_exmem = HOLD;
      choice_memwb = FLUSH;
      div_busy     = inDiv;
      state_d      = MEM_WAIT;
      divPend_d    = inDiv;
`ifdef MEM_TIMEOUT_EN
      waitCnt_d    = waitCnt_q + 10'd1;
`endif
    end else begin
`ifdef MEM_TIMEOUT_EN
      waitCnt_d = '0;
`endif
      divPend_d = 1'b0;
      if (inDiv || ex_div_start) begin
        pc_we        = 1'b0;
        choice_ifid  = HOLD;
        choice_idex  = HOLD;
        choice_exmem = FLUSH;
        choice_memwb = LOAD;
        div_busy     = 1'b1;
        if (!inDiv) begin
          divCnt_d = DIV_LOAD;
          state_d  = DIV_WAIT;
        end else if (divCnt_q == 6'd0) begin
          state_d  = RUN;
        end else begin
          divCnt_d = divCnt_q - 6'd1;
          state_d  = DIV_WAIT;
        end
      end else begin
        state_d = RUN;
        if (loadUse) begin
          pc_we       = 1'b0;
          choice_ifid = HOLD;
          choice_idex = FLUSH;
        end
      end
    end

    if (reset) begin
      pc_we        = 1'b0;
      choice_ifid  = FLUSH;
      choice_idex  = FLUSH;
      choice_exmem = FLUSH;
      choice_memwb = FLUSH;
      div_busy     = 1'b0;
      exc_ack      = 1'b0;
      bus_err      = 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl with DIV_CYCLES=8, MEM_TIMEOUT=4.
// Inputs change on the falling edge, and outputs are sampled 1 ns later.
// Each step then advances to the next falling edge.
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       id_use_rs, id_use_rt, ex_mem_read, ex_div_start;
  logic       mem_req, mem_ready, exc_req;
  logic       pc_we, div_busy, exc_ack, bus_err;
  logic [1:0] choice_ifid, choice_idex, choice_exmem, choice_memwb;

  int total = 0;
  int bad   = 0;

  // Output vector: {pc_we, ifid, idex, exmem, memwb, div_busy, exc_ack, bus_err}
  localparam logic [11:0] NORM = 12'b1_01_01_01_01_000;
  localparam logic [11:0] LU   = 12'b0_10_00_01_01_000;
  localparam logic [11:0] DIVV = 12'b0_10_10_00_01_100;
  localparam logic [11:0] MEMW = 12'b0_10_10_10_00_000;
  localparam logic [11:0] MEMD = 12'b0_10_10_10_00_100;
  localparam logic [11:0] EXC  = 12'b1_00_00_00_00_010;
  localparam logic [11:0] BERR = 12'b1_00_00_00_00_001;
  localparam logic [11:0] RSTV = 12'b0_00_00_00_00_000;

  logic [11:0] outVec;
  assign outVec = {pc_we, choice_ifid, choice_idex, choice_exmem, choice_memwb,
                   div_busy, exc_ack, bus_err};

  pipe_hazard_ctrl #(.DIV_CYCLES(8), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_div_start(ex_div_start),
    .mem_req(mem_req), .mem_ready(mem_ready), .exc_req(exc_req),
    .pc_we(pc_we), .choice_ifid(choice_ifid), .choice_idex(choice_idex),
    .choice_exmem(choice_exmem), .choice_memwb(choice_memwb),
    .div_busy(div_busy), .exc_ack(exc_ack), .bus_err(bus_err)
  );

  // 10 ns free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts one comparison and reports it if it differs.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Checks the current cycle's outputs, then moves to the next falling edge.
  task automatic applyStimulus(input string tag, input logic [11:0] expected);
    #1;
    checkOutput(tag, outVec, expected);
    @(negedge clk);
  endtask

  task automatic clearInputs();
    id_rs = 0; id_rt = 0; ex_rd = 0;
    id_use_rs = 0; id_use_rt = 0; ex_mem_read = 0; ex_div_start = 0;
    mem_req = 0; mem_ready = 0; exc_req = 0;
  endtask

  initial begin
    int badCycles;
    clearInputs();
    reset = 1'b1;
    #2 checkOutput("reset_vals", outVec, RSTV);
    #5 checkOutput("reset_after_edge", outVec, RSTV);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus("idle", NORM);

    // Load-use hazards.
    ex_mem_read = 1; ex_rd = 5; id_rs = 5; id_use_rs = 1;
    applyStimulus("lu_rs", LU);
    ex_mem_read = 0;
    applyStimulus("lu_after", NORM);
    ex_mem_read = 1; ex_rd = 7; id_rs = 1; id_rt = 7; id_use_rs = 1; id_use_rt = 1;
    applyStimulus("lu_rt", LU);
    id_use_rt = 0;
    applyStimulus("lu_not_used", NORM);
    ex_rd = 0; id_rs = 0; id_rt = 0; id_use_rs = 1; id_use_rt = 1;
    applyStimulus("lu_r0", NORM);
    clearInputs();

    // Divide: exactly 8 stall cycles.
    ex_div_start = 1;
    applyStimulus("div_start", DIVV);
    ex_div_start = 0;
    for (int i = 1; i < 8; i++) applyStimulus("div_wait", DIVV);
    applyStimulus("div_end", NORM);

    // Divide interrupted by a 3-cycle memory wait.
    ex_div_start = 1;
    applyStimulus("dm_start", DIVV);
    ex_div_start = 0;
    applyStimulus("dm_div1", DIVV);
    applyStimulus("dm_div2", DIVV);
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) applyStimulus("dm_memwait", MEMD);
    mem_req = 0;
    for (int i = 0; i < 5; i++) applyStimulus("dm_resume", DIVV);
    applyStimulus("dm_end", NORM);

    // Exception on the 4th divide cycle.
    ex_div_start = 1;
    applyStimulus("ex_div1", DIVV);
    ex_div_start = 0;
    applyStimulus("ex_div2", DIVV);
    applyStimulus("ex_div3", DIVV);
    exc_req = 1;
    applyStimulus("ex_flush", EXC);
    exc_req = 0;
    applyStimulus("ex_after", NORM);

    // Exception and divide start together: divide is discarded.
    exc_req = 1; ex_div_start = 1;
    applyStimulus("ex_div_same", EXC);
    clearInputs();
    applyStimulus("ex_div_dropped", NORM);

    // Exception during a memory wait.
    mem_req = 1;
    applyStimulus("mw_stall", MEMW);
    exc_req = 1;
    applyStimulus("mw_exc", EXC);
    clearInputs();
    applyStimulus("mw_exc_after", NORM);

    // Memory ready in the same cycle: no stall.
    mem_req = 1; mem_ready = 1;
    applyStimulus("mem_ready_now", NORM);
    clearInputs();

    // Memory timeout behaviour.
    mem_req = 1; mem_ready = 0;
`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < 3; i++) applyStimulus("to_wait", MEMW);
    applyStimulus("to_buserr", BERR);
    applyStimulus("to_rewait", MEMW);
`else
    badCycles = 0;
    for (int i = 0; i < 1000; i++) begin
      #1;
      if (outVec !== MEMW) badCycles++;
      @(negedge clk);
    end
    checkOutput("long_wait_bad_cycles", badCycles, 0);
`endif
    clearInputs();
    applyStimulus("to_release", NORM);

    // Asynchronous reset in the middle of a divide.
    ex_div_start = 1;
    applyStimulus("ar_div1", DIVV);
    ex_div_start = 0;
    applyStimulus("ar_div2", DIVV);
    #2 reset = 1'b1;
    #1 checkOutput("ar_async", outVec, RSTV);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus("ar_run1", NORM);
    applyStimulus("ar_run2", NORM);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
